// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] constants and lane indexing helpers used by all step modules.
package keccak_pkg;

    localparam int STATE_SIZE = 1600;
    localparam int Z_WIDTH    = 64;
    localparam int NUM_LANES  = STATE_SIZE / Z_WIDTH;
    localparam int CD_SIZE    = 5 * Z_WIDTH;
    localparam int ROUND_W    = 5;

    // Flat lane number for column x and row y of the 5x5 lane grid.
    function automatic int lane_idx(input int x, input int y);
        return 5 * y + x;
    endfunction

endpackage

// File: rtl/theta_parity.sv
// Combinational column parity for theta: C[x][z] is the XOR of the five lanes in column x.
// C[x][z] sits at bit x*Z_WIDTH + z of o_c.
module theta_parity
    import keccak_pkg::*;
(
    input  logic [0:STATE_SIZE-1] i_state,
    output logic [0:CD_SIZE-1]    o_c
);

    // Fold the five rows of each column together, bit by bit.
    always_comb begin
        o_c = '0;
        for (int x = 0; x < 5; x++) begin
            for (int z = 0; z < Z_WIDTH; z++) begin
                for (int y = 0; y < 5; y++) begin
                    o_c[x*Z_WIDTH + z] = o_c[x*Z_WIDTH + z] ^ i_state[lane_idx(x, y)*Z_WIDTH + z];
                end
            end
        end
    end

endmodule

// File: rtl/theta_stage.sv
// Two-stage registered Keccak theta step with valid/ready on both sides.
// Stage 1 captures the state and its column parities; stage 2 applies D and
// presents the mixed state to the rho step. Round tags ride along untouched.
module theta_stage
    import keccak_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [0:STATE_SIZE-1] IN,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [ROUND_W-1:0]    IN_ROUND,
    input  logic                  IN_LAST,
    output logic [0:STATE_SIZE-1] OUT,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [ROUND_W-1:0]    OUT_ROUND,
    output logic                  OUT_LAST
);

    logic [0:CD_SIZE-1]    w_c;
    logic [0:CD_SIZE-1]    w_d;
    logic [0:STATE_SIZE-1] w_theta;
    logic                  w_s1_adv;
    logic                  w_s2_adv;

    logic [0:STATE_SIZE-1] r_s1_state;
    logic [0:CD_SIZE-1]    r_s1_c;
    logic [ROUND_W-1:0]    r_s1_round;
    logic                  r_s1_last;
    logic                  r_s1_valid;
    logic                  r_s2_valid;

    theta_parity u_parity (
        .i_state (IN),
        .o_c     (w_c)
    );

    // A stage may move when its successor is empty or moving; ready never looks at IN_VALID.
    assign w_s2_adv  = !r_s2_valid || OUT_READY;
    assign w_s1_adv  = !r_s1_valid || w_s2_adv;
    assign IN_READY  = w_s1_adv;
    assign OUT_VALID = r_s2_valid;

    // Stage 1: capture state, column parities and tags on an accepted input.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s1_valid <= 1'b0;
            r_s1_state <= '0;
            r_s1_c     <= '0;
            r_s1_round <= '0;
            r_s1_last  <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= IN_VALID;
            if (IN_VALID) begin
                r_s1_state <= IN;
                r_s1_c     <= w_c;
                r_s1_round <= IN_ROUND;
                r_s1_last  <= IN_LAST;
            end
        end
    end

    // D[x][z] combines the left neighbour column with the right neighbour column shifted by one in z.
    always_comb begin
        w_d = '0;
        for (int x = 0; x < 5; x++) begin
            for (int z = 0; z < Z_WIDTH; z++) begin
                w_d[x*Z_WIDTH + z] = r_s1_c[((x + 4) % 5)*Z_WIDTH + z]
                                   ^ r_s1_c[((x + 1) % 5)*Z_WIDTH + ((z + Z_WIDTH - 1) % Z_WIDTH)];
            end
        end
    end

    // Every lane in column x is XORed with the same D[x].
    always_comb begin
        w_theta = r_s1_state;
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                for (int z = 0; z < Z_WIDTH; z++) begin
                    w_theta[lane_idx(x, y)*Z_WIDTH + z] =
                        r_s1_state[lane_idx(x, y)*Z_WIDTH + z] ^ w_d[x*Z_WIDTH + z];
                end
            end
        end
    end

    // Stage 2: register the theta result; it holds while the consumer stalls.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_s2_valid <= 1'b0;
            OUT        <= '0;
            OUT_ROUND  <= '0;
            OUT_LAST   <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                OUT       <= w_theta;
                OUT_ROUND <= r_s1_round;
                OUT_LAST  <= r_s1_last;
            end
        end
    end

endmodule

// File: tb/tb_theta_stage.sv
// Self-checking bench for theta_stage: directed vectors, streaming, backpressure and mid-flight reset.
module tb_theta_stage;
    import keccak_pkg::*;

    logic                  CLK = 1'b0;
    logic                  RST_N;
    logic [0:STATE_SIZE-1] IN;
    logic                  IN_VALID;
    logic                  IN_READY;
    logic [ROUND_W-1:0]    IN_ROUND;
    logic                  IN_LAST;
    logic [0:STATE_SIZE-1] OUT;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [ROUND_W-1:0]    OUT_ROUND;
    logic                  OUT_LAST;

    theta_stage dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .IN        (IN),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_ROUND  (IN_ROUND),
        .IN_LAST   (IN_LAST),
        .OUT       (OUT),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_ROUND (OUT_ROUND),
        .OUT_LAST  (OUT_LAST)
    );

    // 10 ns clock.
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int outCount = 0;

    typedef struct {
        logic [0:STATE_SIZE-1] state;
        logic [ROUND_W-1:0]    round;
        logic                  last;
    } item_t;

    typedef struct {
        string                 name;
        logic [0:STATE_SIZE-1] state;
        logic [ROUND_W-1:0]    round;
        logic                  last;
        logic [0:STATE_SIZE-1] expected;
    } vec_t;

    item_t scoreQ[$];
    item_t monItem;
    vec_t  vecs[4];

    // Cycle counter used for latency measurements.
    always @(posedge CLK) cycle <= cycle + 1;

    // Reference theta in the lane-word form: D[x] = C[x-1] ^ rotl(C[x+1], 1).
    function automatic logic [0:STATE_SIZE-1] thetaModel(input logic [0:STATE_SIZE-1] s);
        logic [63:0] a [25];
        logic [63:0] c [5];
        logic [63:0] d [5];
        logic [0:STATE_SIZE-1] r;
        for (int i = 0; i < 25; i++)
            for (int z = 0; z < 64; z++)
                a[i][z] = s[i*64 + z];
        for (int x = 0; x < 5; x++)
            c[x] = a[x] ^ a[x+5] ^ a[x+10] ^ a[x+15] ^ a[x+20];
        for (int x = 0; x < 5; x++)
            d[x] = c[(x+4)%5] ^ {c[(x+1)%5][62:0], c[(x+1)%5][63]};
        for (int i = 0; i < 25; i++)
            for (int z = 0; z < 64; z++)
                r[i*64 + z] = a[i][z] ^ d[i%5][z];
        return r;
    endfunction

    function automatic logic [0:STATE_SIZE-1] randomState();
        logic [0:STATE_SIZE-1] s;
        for (int w = 0; w < STATE_SIZE/32; w++)
            s[w*32 +: 32] = $urandom();
        return s;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkState(input string name, input logic [0:STATE_SIZE-1] act,
                              input logic [0:STATE_SIZE-1] exp);
        int lane;
        checks++;
        if (act !== exp) begin
            lane = 0;
            for (int i = NUM_LANES-1; i >= 0; i--)
                if (act[i*Z_WIDTH +: Z_WIDTH] !== exp[i*Z_WIDTH +: Z_WIDTH]) lane = i;
            errors++;
            $display("[TB] FAIL %s lane=%0d actual=%h required=%h", name, lane,
                     act[lane*Z_WIDTH +: Z_WIDTH], exp[lane*Z_WIDTH +: Z_WIDTH]);
        end
    endtask

    // Scoreboard: pop and compare on every output transfer, push the model result on every input transfer.
    always @(negedge CLK) begin
        if (!RST_N) begin
            scoreQ.delete();
        end else begin
            if (OUT_VALID && OUT_READY) begin
                outCount++;
                if (scoreQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected actual=output required=none");
                end else begin
                    monItem = scoreQ.pop_front();
                    checkState("sb_data", OUT, monItem.state);
                    checkOutput("sb_round", 64'(OUT_ROUND), 64'(monItem.round));
                    checkOutput("sb_last", 64'(OUT_LAST), 64'(monItem.last));
                end
            end
            if (IN_VALID && IN_READY) begin
                monItem.state = thetaModel(IN);
                monItem.round = IN_ROUND;
                monItem.last  = IN_LAST;
                scoreQ.push_back(monItem);
            end
        end
    end

    // Offer one state and wait (bounded) until it is accepted; returns the cycle it was presented in.
    task automatic applyStimulus(input logic [0:STATE_SIZE-1] s, input logic [ROUND_W-1:0] rnd,
                                 input logic lst, output int acceptCycle);
        int guard;
        @(posedge CLK); #1;
        IN = s;
        IN_ROUND = rnd;
        IN_LAST = lst;
        IN_VALID = 1'b1;
        guard = 0;
        @(negedge CLK);
        while (!IN_READY && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        if (!IN_READY) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=0 required=1");
        end
        acceptCycle = cycle;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
    endtask

    task automatic waitForOutput(output int outCycle);
        int guard;
        guard = 0;
        @(negedge CLK);
        while (!OUT_VALID && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        if (!OUT_VALID) begin
            checks++;
            errors++;
            $display("[TB] FAIL out_timeout actual=0 required=1");
        end
        outCycle = cycle;
    endtask

    task automatic drainPipe(input string name);
        int guard;
        guard = 0;
        while ((OUT_VALID || scoreQ.size() != 0) && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        checks++;
        if (OUT_VALID || scoreQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s actual=pending(%0d) required=empty", name, scoreQ.size());
        end
    endtask

    // Hard stop in case something stalls beyond every bounded wait.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int accCyc;
        int outCyc;
        int idx;
        int outBase;
        logic [0:STATE_SIZE-1] held;
        logic [ROUND_W-1:0] heldRound;
        item_t bp [3];
        logic [0:STATE_SIZE-1] rs;

        // Directed vectors with hand-derived expected results.
        vecs[0].name = "zero";
        vecs[0].state = '0;
        vecs[0].round = 5'd3;
        vecs[0].last = 1'b0;
        vecs[0].expected = '0;

        vecs[1].name = "ones";
        vecs[1].state = '1;
        vecs[1].round = 5'd31;
        vecs[1].last = 1'b1;
        vecs[1].expected = '1;

        vecs[2].name = "bit_l0z0";
        vecs[2].state = '0;
        vecs[2].state[0] = 1'b1;
        vecs[2].round = 5'd7;
        vecs[2].last = 1'b0;
        vecs[2].expected = '0;
        vecs[2].expected[0] = 1'b1;
        foreach (vecs[2].expected[b]) begin
        end
        for (int y = 0; y < 5; y++) begin
            vecs[2].expected[(5*y + 1)*64 + 0] = 1'b1;
            vecs[2].expected[(5*y + 4)*64 + 1] = 1'b1;
        end

        vecs[3].name = "bit_l24z63";
        vecs[3].state = '0;
        vecs[3].state[24*64 + 63] = 1'b1;
        vecs[3].round = 5'd18;
        vecs[3].last = 1'b1;
        vecs[3].expected = '0;
        vecs[3].expected[24*64 + 63] = 1'b1;
        for (int y = 0; y < 5; y++) begin
            vecs[3].expected[(5*y + 0)*64 + 63] = 1'b1;
            vecs[3].expected[(5*y + 3)*64 + 0] = 1'b1;
        end

        // Reset state.
        RST_N = 1'b0;
        IN = '0;
        IN_VALID = 1'b0;
        IN_ROUND = '0;
        IN_LAST = 1'b0;
        OUT_READY = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("rst_out_valid", 64'(OUT_VALID), 64'd0);
        checkState("rst_out", OUT, '0);
        checkOutput("rst_out_round", 64'(OUT_ROUND), 64'd0);
        checkOutput("rst_out_last", 64'(OUT_LAST), 64'd0);
        #2 RST_N = 1'b1;
        @(negedge CLK);
        checkOutput("rst_in_ready", 64'(IN_READY), 64'd1);
        checkOutput("rst_idle_valid", 64'(OUT_VALID), 64'd0);

        // Table-driven single transfers with latency and data checks.
        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].state, vecs[v].round, vecs[v].last, accCyc);
            waitForOutput(outCyc);
            checkOutput({vecs[v].name, "_latency"}, 64'(outCyc - accCyc), 64'd2);
            checkState(vecs[v].name, OUT, vecs[v].expected);
            checkOutput({vecs[v].name, "_round"}, 64'(OUT_ROUND), 64'(vecs[v].round));
            checkOutput({vecs[v].name, "_last"}, 64'(OUT_LAST), 64'(vecs[v].last));
            drainPipe({vecs[v].name, "_drain"});
        end

        // Back-to-back stream of 24 random states at full rate.
        outBase = outCount;
        for (int j = 0; j < 27; j++) begin
            @(posedge CLK); #1;
            if (j < 24) begin
                IN = randomState();
                IN_ROUND = ROUND_W'(j);
                IN_LAST = (j == 23);
                IN_VALID = 1'b1;
            end else begin
                IN_VALID = 1'b0;
            end
            @(negedge CLK);
            if (j < 24) checkOutput("b2b_in_ready", 64'(IN_READY), 64'd1);
            checkOutput("b2b_out_valid", 64'(OUT_VALID), 64'(j >= 2 && j < 26));
            if (OUT_VALID) checkOutput("b2b_out_last", 64'(OUT_LAST), 64'(j == 25));
        end
        drainPipe("b2b_drain");
        checkOutput("b2b_count", 64'(outCount - outBase), 64'd24);

        // Backpressure: three offers against a stalled consumer for five cycles.
        for (int k = 0; k < 3; k++) begin
            bp[k].state = randomState();
            bp[k].round = ROUND_W'(10 + k);
            bp[k].last = (k == 2);
        end
        outBase = outCount;
        idx = 0;
        held = '0;
        heldRound = '0;
        for (int j = 0; j < 5; j++) begin
            @(posedge CLK); #1;
            OUT_READY = 1'b0;
            if (idx < 3) begin
                IN = bp[idx].state;
                IN_ROUND = bp[idx].round;
                IN_LAST = bp[idx].last;
                IN_VALID = 1'b1;
            end else begin
                IN_VALID = 1'b0;
            end
            @(negedge CLK);
            checkOutput("bp_in_ready", 64'(IN_READY), 64'(j < 2));
            if (j >= 2) begin
                checkOutput("bp_out_valid", 64'(OUT_VALID), 64'd1);
                if (j == 2) begin
                    held = OUT;
                    heldRound = OUT_ROUND;
                    checkState("bp_first_data", OUT, thetaModel(bp[0].state));
                end else begin
                    checkState("bp_hold", OUT, held);
                    checkOutput("bp_hold_round", 64'(OUT_ROUND), 64'(heldRound));
                end
            end
            if (IN_VALID && IN_READY) idx++;
        end
        checkOutput("bp_accepted", 64'(idx), 64'd2);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        for (int g = 0; g < 10 && idx < 3; g++) begin
            @(negedge CLK);
            if (IN_VALID && IN_READY) idx++;
            @(posedge CLK); #1;
            if (idx >= 3) IN_VALID = 1'b0;
        end
        IN_VALID = 1'b0;
        checkOutput("bp_all_accepted", 64'(idx), 64'd3);
        @(negedge CLK);
        drainPipe("bp_drain");
        checkOutput("bp_count", 64'(outCount - outBase), 64'd3);

        // Reset with two states in flight, then a fresh transfer.
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        IN = randomState();
        IN_ROUND = 5'd20;
        IN_LAST = 1'b0;
        IN_VALID = 1'b1;
        @(posedge CLK); #1;
        IN = randomState();
        IN_ROUND = 5'd21;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        @(negedge CLK);
        checkOutput("inflight_valid", 64'(OUT_VALID), 64'd1);
        checkOutput("inflight_full_ready", 64'(IN_READY), 64'd0);
        #2 RST_N = 1'b0;
        #1;
        checkOutput("rst_async_valid", 64'(OUT_VALID), 64'd0);
        checkOutput("rst_async_last", 64'(OUT_LAST), 64'd0);
        checkOutput("rst_async_round", 64'(OUT_ROUND), 64'd0);
        @(negedge CLK);
        @(posedge CLK); #2;
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        @(negedge CLK);
        checkOutput("post_rst_valid", 64'(OUT_VALID), 64'd0);
        checkOutput("post_rst_queue", 64'(scoreQ.size()), 64'd0);
        rs = randomState();
        applyStimulus(rs, 5'd9, 1'b1, accCyc);
        waitForOutput(outCyc);
        checkOutput("post_rst_latency", 64'(outCyc - accCyc), 64'd2);
        checkState("post_rst_data", OUT, thetaModel(rs));
        checkOutput("post_rst_round", 64'(OUT_ROUND), 64'd9);
        drainPipe("post_rst_drain");

        checkOutput("final_queue", 64'(scoreQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/theta_stage.md
Name: theta_stage

Overview:
- Registered, handshaked Keccak-f[1600] theta step. It sits directly upstream of the combinational rho step and feeds it the theta-mixed state.
- Two-stage pipeline:
  - stage 1 registers the input state together with the 320 column parities C.
  - stage 2 applies D = C[x-1][z] ^ C[x+1][z-1] to every lane and registers the result.
- Valid/ready on both sides, so the round datapath can stall without data loss. The round index and a last-round flag travel with each state.

Parameters:
- STATE_SIZE, 1600: state width in bits.
- Z_WIDTH, 64: lane width; lane count = STATE_SIZE/Z_WIDTH = 25.
- CD_SIZE, 320: width of the C and D vectors, 5*Z_WIDTH.
- ROUND_W, 5: width of the round tag carried alongside the state.

Ports:
- CLK  in  1  clock; all registers use the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN  in  [0:STATE_SIZE-1]  input state.
  - Lane i occupies bits i*64 .. i*64+63, with i = 5*y + x.
  - Bit z of a lane is at offset z.
- IN_VALID  in  1  IN, IN_ROUND and IN_LAST are valid.
- IN_READY  out  1  stage accepts the input this cycle.
- IN_ROUND  in  ROUND_W  round index tag.
- IN_LAST  in  1  last-round tag.
- OUT  out  [0:STATE_SIZE-1]  theta result, same lane/bit layout as IN; it feeds the rho step directly.
- OUT_VALID  out  1  OUT and its tags are valid.
- OUT_READY  in  1  downstream accepts OUT.
- OUT_ROUND  out  ROUND_W  tag delivered with OUT.
- OUT_LAST  out  1  tag delivered with OUT.

Behaviour:
- Reset (RST_N low, asynchronous): s1_valid=0, s2_valid=0, OUT=0, OUT_ROUND=0, OUT_LAST=0, OUT_VALID=0. IN_READY is 1 from the first cycle after reset deassertion.
- Reset mid-operation discards all in-flight states; no partial output is ever presented.
- Stage 1 (per cycle, when enabled):
  - C[x][z] = XOR over y of IN bit (5y+x)*64+z.
  - The state, C and the tags are registered when IN_VALID & IN_READY.
- Stage 2:
  - D[x][z] = C[(x+4)%5][z] ^ C[(x+1)%5][(z+63)%64].
  - OUT bit (5y+x)*64+z = s1_state at the same bit ^ D[x][z].
  - All indices wrap modulo 5 and modulo 64.
- Handshake:
  - s2_adv = !s2_valid | OUT_READY.
  - s1_adv = !s1_valid | s2_adv.
  - IN_READY = s1_adv, combinational and not dependent on IN_VALID.
  - Stage 1 loads when IN_VALID & s1_adv. s1_valid is set to IN_VALID whenever s1_adv.
  - Stage 2 loads when s1_valid & s2_adv. s2_valid is set to s1_valid whenever s2_adv.
- Latency: 2 cycles from an accepted input to OUT_VALID with no backpressure.
- Throughput: 1 state per cycle while OUT_READY stays high.
- OUT_VALID=1 with OUT_READY=0 holds OUT, OUT_ROUND and OUT_LAST stable until the transfer completes.
- Full pipeline (both stages valid, OUT_READY=0): IN_READY=0.
- Simultaneous drain and fill: when OUT_READY=1, IN_READY=1 in the same cycle and no bubble is inserted.
- Empty pipeline: OUT_VALID=0. OUT contents are don't-care but must not be X after reset.
- Tags are never modified; they propagate unchanged with their state.
- No combinational path from IN to OUT.

Decomposition:
- Shared package keccak_pkg:
  - STATE_SIZE, Z_WIDTH, CD_SIZE, ROUND_W, NUM_LANES.
  - A lane_idx(x,y) = 5*y+x function.
  - Reused by the rho, pi, chi and iota steps.
- One natural sub-module, theta_parity: combinational, IN to C[0:CD_SIZE-1]. It is reusable by a future slice-serial variant.
- D generation and the XOR stay inline in theta_stage.

Test Plan:
- All-zero IN, round tag 3 → after 2 cycles OUT=0, OUT_ROUND=3.
- All-ones IN → every C bit = 1, D = 0 → OUT all ones.
- Single bit: lane 0 bit 0 set → OUT has exactly 11 bits set:
  - lane 0 bit 0;
  - bit 0 of lanes 1, 6, 11, 16, 21;
  - bit 1 of lanes 4, 9, 14, 19, 24.
- Back-to-back: 24 random states with OUT_READY=1 → 24 outputs on consecutive cycles starting at cycle 2. Results match the reference model; tags are in order; OUT_LAST=1 only on the 24th.
- Backpressure: hold OUT_READY=0 for 5 cycles with 3 inputs offered → IN_READY falls after 2 accepts and OUT stays stable. On release, all 3 states emerge in order and none is lost or duplicated.
- Assert RST_N=0 with 2 states in flight, then release → OUT_VALID=0 immediately. The next accepted state emerges 2 cycles after acceptance with correct data.
